// File: rtl/multi_channel_press_detector.sv
`default_nettype none
// ============================================================================
// multi_channel_press_detector: N-channel button sync, debounce and press/hold/release events
// Rev 1.0
// ============================================================================
module multi_channel_press_detector #(
    parameter int N_CH        = 4,
    parameter int TICK_DIV    = 100000,
    parameter int DB_TICKS    = 20,
    parameter int HOLD_TICKS  = 1000,
    parameter int ACTIVE_LOW  = 0,
    parameter int STICKY_HOLD = 1
) (
    input  logic            sys_clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] btn_in,
    input  logic [N_CH-1:0] clear,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] press_pulse,
    output logic [N_CH-1:0] hold_pulse,
    output logic [N_CH-1:0] release_pulse,
    output logic [N_CH-1:0] hold_level,
    output logic            tick
);

    localparam int c_tick_w  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int c_cnt_top = (DB_TICKS > HOLD_TICKS) ? DB_TICKS : HOLD_TICKS;
    localparam int c_cnt_w   = $clog2(c_cnt_top + 1);

    localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(TICK_DIV - 1);
    localparam logic [c_cnt_w-1:0]  c_db_last   = c_cnt_w'(DB_TICKS - 1);
    localparam logic [c_cnt_w-1:0]  c_hold_last = c_cnt_w'(HOLD_TICKS - 1);
    localparam logic [c_cnt_w-1:0]  c_cnt_zero  = '0;
    localparam logic [c_cnt_w-1:0]  c_cnt_one   = c_cnt_w'(1);
    localparam logic                c_sticky    = (STICKY_HOLD != 0);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_PRESS_DB   = 3'd1,
        S_PRESSED    = 3'd2,
        S_HELD       = 3'd3,
        S_RELEASE_DB = 3'd4,
        S_LOCKOUT    = 3'd5
    } state_t;

    logic [N_CH-1:0]     w_norm;
    logic [N_CH-1:0]     r_sync1;
    logic [N_CH-1:0]     r_sync2;
    logic [c_tick_w-1:0] r_tick_cnt;
    logic                w_tick;

    assign w_norm = btn_in ^ {N_CH{(ACTIVE_LOW != 0)}};

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_norm;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_cnt <= '0;
        end else if (r_tick_cnt == c_tick_last) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + c_tick_w'(1);
        end
    end

    assign w_tick = (r_tick_cnt == c_tick_last);
    assign tick   = w_tick;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        state_t             r_state, w_state_nxt;
        logic [c_cnt_w-1:0] r_cnt, w_cnt_nxt;
        logic [c_cnt_w-1:0] r_shadow, w_shadow_nxt;
        logic               r_ret_held, w_ret_held_nxt;
        logic               r_hold_lvl, w_hold_lvl_nxt;
        logic               w_press, w_hold, w_rel;
        logic               r_level, r_press, r_hold, r_rel;
        logic               w_s;

        assign w_s = r_sync2[gi];

        always_ff @(posedge sys_clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state    <= S_IDLE;
                r_cnt      <= '0;
                r_shadow   <= '0;
                r_ret_held <= 1'b0;
                r_hold_lvl <= 1'b0;
                r_level    <= 1'b0;
                r_press    <= 1'b0;
                r_hold     <= 1'b0;
                r_rel      <= 1'b0;
            end else begin
                r_state    <= w_state_nxt;
                r_cnt      <= w_cnt_nxt;
                r_shadow   <= w_shadow_nxt;
                r_ret_held <= w_ret_held_nxt;
                r_hold_lvl <= w_hold_lvl_nxt;
                r_level    <= (w_state_nxt == S_PRESSED) || (w_state_nxt == S_HELD) ||
                              (w_state_nxt == S_RELEASE_DB);
                r_press    <= w_press;
                r_hold     <= w_hold;
                r_rel      <= w_rel;
            end
        end

        always_comb begin
            w_state_nxt    = r_state;
            w_cnt_nxt      = r_cnt;
            w_shadow_nxt   = r_shadow;
            w_ret_held_nxt = r_ret_held;
            w_hold_lvl_nxt = r_hold_lvl;
            w_press        = 1'b0;
            w_hold         = 1'b0;
            w_rel          = 1'b0;
            if (clear[gi]) begin
                // A button still down at clear time must be seen released before re-arming
                w_state_nxt    = w_s ? S_LOCKOUT : S_IDLE;
                w_cnt_nxt      = c_cnt_zero;
                w_shadow_nxt   = c_cnt_zero;
                w_ret_held_nxt = 1'b0;
                w_hold_lvl_nxt = 1'b0;
            end else if (w_tick) begin
                case (r_state)
                    S_IDLE: begin
                        if (w_s) begin
                            if (DB_TICKS == 1) begin
                                w_state_nxt = S_PRESSED;
                                w_cnt_nxt   = c_cnt_zero;
                                w_press     = 1'b1;
                            end else begin
                                w_state_nxt = S_PRESS_DB;
                                w_cnt_nxt   = c_cnt_one;
                            end
                        end
                    end
                    S_PRESS_DB: begin
                        if (!w_s) begin
                            w_state_nxt = S_IDLE;
                            w_cnt_nxt   = c_cnt_zero;
                        end else if (r_cnt == c_db_last) begin
                            w_state_nxt = S_PRESSED;
                            w_cnt_nxt   = c_cnt_zero;
                            w_press     = 1'b1;
                        end else begin
                            w_cnt_nxt = r_cnt + c_cnt_one;
                        end
                    end
                    S_PRESSED: begin
                        if (w_s) begin
                            w_cnt_nxt = r_cnt + c_cnt_one;
                            if (r_cnt == c_hold_last) begin
                                w_state_nxt    = S_HELD;
                                w_hold         = 1'b1;
                                w_hold_lvl_nxt = 1'b1;
                            end
                        end else begin
                            // Park the hold count so a bounce resumes hold timing where it stopped
                            w_shadow_nxt   = r_cnt;
                            w_ret_held_nxt = 1'b0;
                            if (DB_TICKS == 1) begin
                                w_state_nxt    = S_IDLE;
                                w_cnt_nxt      = c_cnt_zero;
                                w_rel          = 1'b1;
                                w_hold_lvl_nxt = c_sticky & r_hold_lvl;
                            end else begin
                                w_state_nxt = S_RELEASE_DB;
                                w_cnt_nxt   = c_cnt_one;
                            end
                        end
                    end
                    S_HELD: begin
                        if (!w_s) begin
                            w_shadow_nxt   = r_cnt;
                            w_ret_held_nxt = 1'b1;
                            if (DB_TICKS == 1) begin
                                w_state_nxt    = S_IDLE;
                                w_cnt_nxt      = c_cnt_zero;
                                w_rel          = 1'b1;
                                w_hold_lvl_nxt = c_sticky & r_hold_lvl;
                            end else begin
                                w_state_nxt = S_RELEASE_DB;
                                w_cnt_nxt   = c_cnt_one;
                            end
                        end
                    end
                    S_RELEASE_DB: begin
                        if (w_s) begin
                            w_state_nxt = r_ret_held ? S_HELD : S_PRESSED;
                            w_cnt_nxt   = r_shadow;
                        end else if (r_cnt == c_db_last) begin
                            w_state_nxt    = S_IDLE;
                            w_cnt_nxt      = c_cnt_zero;
                            w_rel          = 1'b1;
                            w_hold_lvl_nxt = c_sticky & r_hold_lvl;
                        end else begin
                            w_cnt_nxt = r_cnt + c_cnt_one;
                        end
                    end
                    S_LOCKOUT: begin
                        if (w_s) begin
                            w_cnt_nxt = c_cnt_zero;
                        end else if (r_cnt == c_db_last) begin
                            w_state_nxt = S_IDLE;
                            w_cnt_nxt   = c_cnt_zero;
                        end else begin
                            w_cnt_nxt = r_cnt + c_cnt_one;
                        end
                    end
                    default: begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = c_cnt_zero;
                    end
                endcase
            end
        end

        assign btn_level[gi]     = r_level;
        assign press_pulse[gi]   = r_press;
        assign hold_pulse[gi]    = r_hold;
        assign release_pulse[gi] = r_rel;
        assign hold_level[gi]    = r_hold_lvl;
    end

endmodule
`default_nettype wire

// File: tb/tb_multi_channel_press_detector.sv
`default_nettype none
// ============================================================================
// tb_multi_channel_press_detector: randomized bench with run-length reference model
// Rev 1.0
// ============================================================================
module tb_multi_channel_press_detector;

    localparam int N_CH       = 2;
    localparam int TICK_DIV   = 10;
    localparam int DB_TICKS   = 3;
    localparam int HOLD_TICKS = 5;
    localparam int N_DUT      = 3;

    logic            sys_clk = 1'b0;
    logic            rst_n   = 1'b0;
    logic [N_CH-1:0] btn     [N_DUT];
    logic [N_CH-1:0] clr     [N_DUT];
    logic [N_CH-1:0] lvl_o   [N_DUT];
    logic [N_CH-1:0] press_o [N_DUT];
    logic [N_CH-1:0] hold_o  [N_DUT];
    logic [N_CH-1:0] rel_o   [N_DUT];
    logic [N_CH-1:0] hlvl_o  [N_DUT];
    logic            tick_o  [N_DUT];

    // Pressed level per channel, independent of input polarity
    logic [N_CH-1:0] g_press [N_DUT];
    int              n_tests = 0;
    int              n_fail  = 0;

    // Reference model state
    int              m_tcnt;
    logic [N_CH-1:0] m_sync1 [N_DUT];
    logic [N_CH-1:0] m_sync2 [N_DUT];
    bit              m_pressed [N_DUT][N_CH];
    bit              m_long    [N_DUT][N_CH];
    bit              m_locked  [N_DUT][N_CH];
    bit              m_hlvl    [N_DUT][N_CH];
    int              m_hi      [N_DUT][N_CH];
    int              m_lo      [N_DUT][N_CH];
    int              m_acc     [N_DUT][N_CH];
    logic [N_CH-1:0] e_lvl   [N_DUT];
    logic [N_CH-1:0] e_press [N_DUT];
    logic [N_CH-1:0] e_hold  [N_DUT];
    logic [N_CH-1:0] e_rel   [N_DUT];
    logic [N_CH-1:0] e_hlvl  [N_DUT];
    logic            e_tick;

    always #5 sys_clk = ~sys_clk;

    multi_channel_press_detector #(
        .N_CH(N_CH), .TICK_DIV(TICK_DIV), .DB_TICKS(DB_TICKS), .HOLD_TICKS(HOLD_TICKS),
        .ACTIVE_LOW(0), .STICKY_HOLD(1)
    ) u_dut_a (
        .sys_clk(sys_clk), .rst_n(rst_n), .btn_in(btn[0]), .clear(clr[0]),
        .btn_level(lvl_o[0]), .press_pulse(press_o[0]), .hold_pulse(hold_o[0]),
        .release_pulse(rel_o[0]), .hold_level(hlvl_o[0]), .tick(tick_o[0])
    );

    multi_channel_press_detector #(
        .N_CH(N_CH), .TICK_DIV(TICK_DIV), .DB_TICKS(DB_TICKS), .HOLD_TICKS(HOLD_TICKS),
        .ACTIVE_LOW(0), .STICKY_HOLD(0)
    ) u_dut_b (
        .sys_clk(sys_clk), .rst_n(rst_n), .btn_in(btn[1]), .clear(clr[1]),
        .btn_level(lvl_o[1]), .press_pulse(press_o[1]), .hold_pulse(hold_o[1]),
        .release_pulse(rel_o[1]), .hold_level(hlvl_o[1]), .tick(tick_o[1])
    );

    multi_channel_press_detector #(
        .N_CH(N_CH), .TICK_DIV(TICK_DIV), .DB_TICKS(DB_TICKS), .HOLD_TICKS(HOLD_TICKS),
        .ACTIVE_LOW(1), .STICKY_HOLD(1)
    ) u_dut_c (
        .sys_clk(sys_clk), .rst_n(rst_n), .btn_in(btn[2]), .clear(clr[2]),
        .btn_level(lvl_o[2]), .press_pulse(press_o[2]), .hold_pulse(hold_o[2]),
        .release_pulse(rel_o[2]), .hold_level(hlvl_o[2]), .tick(tick_o[2])
    );

    function automatic bit sticky_of(input int k);
        return (k != 1);
    endfunction

    function automatic bit al_of(input int k);
        return (k == 2);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic apply_inputs();
        for (int k = 0; k < N_DUT; k++) btn[k] = al_of(k) ? ~g_press[k] : g_press[k];
    endtask

    task automatic model_reset();
        m_tcnt = 0;
        e_tick = 1'b0;
        for (int k = 0; k < N_DUT; k++) begin
            m_sync1[k] = '0; m_sync2[k] = '0;
            e_lvl[k] = '0; e_press[k] = '0; e_hold[k] = '0; e_rel[k] = '0; e_hlvl[k] = '0;
            for (int c = 0; c < N_CH; c++) begin
                m_pressed[k][c] = 0; m_long[k][c] = 0; m_locked[k][c] = 0; m_hlvl[k][c] = 0;
                m_hi[k][c] = 0; m_lo[k][c] = 0; m_acc[k][c] = 0;
            end
        end
    endtask

    // Debounced level from runs of agreeing ticks; hold time accumulates only on
    // pressed ticks that are not part of a pending release.
    task automatic model_clock();
        bit tick_now;
        bit s;
        tick_now = (m_tcnt == TICK_DIV - 1);
        for (int k = 0; k < N_DUT; k++) begin
            for (int c = 0; c < N_CH; c++) begin
                s = m_sync2[k][c];
                e_press[k][c] = 1'b0; e_hold[k][c] = 1'b0; e_rel[k][c] = 1'b0;
                if (clr[k][c]) begin
                    m_pressed[k][c] = 0; m_long[k][c] = 0; m_hlvl[k][c] = 0;
                    m_hi[k][c] = 0; m_lo[k][c] = 0; m_acc[k][c] = 0;
                    m_locked[k][c] = s;
                end else if (tick_now) begin
                    if (m_locked[k][c]) begin
                        if (s) m_lo[k][c] = 0;
                        else begin
                            m_lo[k][c]++;
                            if (m_lo[k][c] == DB_TICKS) begin m_locked[k][c] = 0; m_lo[k][c] = 0; end
                        end
                    end else if (!m_pressed[k][c]) begin
                        if (s) begin
                            m_hi[k][c]++;
                            if (m_hi[k][c] == DB_TICKS) begin
                                m_pressed[k][c] = 1; m_hi[k][c] = 0; m_acc[k][c] = 0;
                                e_press[k][c] = 1'b1;
                            end
                        end else m_hi[k][c] = 0;
                    end else if (s) begin
                        if (m_lo[k][c] > 0) m_lo[k][c] = 0;
                        else if (!m_long[k][c]) begin
                            m_acc[k][c]++;
                            if (m_acc[k][c] == HOLD_TICKS) begin
                                m_long[k][c] = 1; m_hlvl[k][c] = 1; e_hold[k][c] = 1'b1;
                            end
                        end
                    end else begin
                        m_lo[k][c]++;
                        if (m_lo[k][c] == DB_TICKS) begin
                            m_pressed[k][c] = 0; m_long[k][c] = 0; m_lo[k][c] = 0;
                            e_rel[k][c] = 1'b1;
                            if (!sticky_of(k)) m_hlvl[k][c] = 0;
                        end
                    end
                end
                e_lvl[k][c]  = m_pressed[k][c];
                e_hlvl[k][c] = m_hlvl[k][c];
            end
            m_sync2[k] = m_sync1[k];
            m_sync1[k] = al_of(k) ? ~btn[k] : btn[k];
        end
        m_tcnt = (m_tcnt + 1) % TICK_DIV;
        e_tick = (m_tcnt == TICK_DIV - 1);
    endtask

    task automatic compare_all();
        for (int k = 0; k < N_DUT; k++) begin
            check($sformatf("dut%0d.outs{tick,lvl,press,hold,rel,hlvl}", k),
                  32'({tick_o[k], lvl_o[k], press_o[k], hold_o[k], rel_o[k], hlvl_o[k]}),
                  32'({e_tick, e_lvl[k], e_press[k], e_hold[k], e_rel[k], e_hlvl[k]}));
        end
    endtask

    // One clock: model follows the edge, outputs are compared 1 time unit later
    task automatic step();
        @(posedge sys_clk);
        if (rst_n) model_clock();
        else model_reset();
        #1;
        compare_all();
    endtask

    task automatic async_reset_now();
        rst_n = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < N_DUT; k++)
            check($sformatf("areset.dut%0d", k),
                  32'({tick_o[k], lvl_o[k], press_o[k], hold_o[k], rel_o[k], hlvl_o[k]}), 32'd0);
    endtask

    // Run n cycles, returning the cycle index of the first press/hold on dut0 ch0
    task automatic run_measure(input int n, output int t_press, output int t_hold, output bit both_c);
        t_press = -1; t_hold = -1; both_c = 0;
        for (int j = 1; j <= n; j++) begin
            step();
            if (press_o[0][0] && t_press < 0) t_press = j;
            if (hold_o[0][0] && t_hold < 0) t_hold = j;
            if (press_o[2] == 2'b11) both_c = 1;
        end
    endtask

    int dur   [N_DUT][N_CH];
    int clr_n [N_DUT][N_CH];

    initial begin
        int  tp, th;
        bit  both;
        model_reset();
        for (int k = 0; k < N_DUT; k++) begin g_press[k] = '0; clr[k] = '0; end
        apply_inputs();
        #1;
        for (int j = 0; j < 3; j++) step();

        // Clean simultaneous press on every channel from a fresh reset
        rst_n = 1'b1;
        for (int k = 0; k < N_DUT; k++) g_press[k] = 2'b11;
        apply_inputs();
        run_measure(100, tp, th, both);
        check("press.latency", 32'(tp), 32'(3 * TICK_DIV));
        check("hold.gap", 32'(th - tp), 32'(HOLD_TICKS * TICK_DIV));
        check("activelow.both_press", 32'(both), 32'd1);

        // Reset mid-hold, then a full debounce is needed again
        async_reset_now();
        for (int j = 0; j < 3; j++) step();
        rst_n = 1'b1;
        run_measure(90, tp, th, both);
        check("press.latency_after_reset", 32'(tp), 32'(3 * TICK_DIV));

        // Clear ch1 while held; button stays down 20 ticks, then everything releases
        for (int k = 0; k < N_DUT; k++) clr[k] = 2'b10;
        step();
        for (int k = 0; k < N_DUT; k++) clr[k] = 2'b00;
        check("clear.ch1_level", 32'(lvl_o[0][1]), 32'd0);
        check("clear.ch1_hold_level", 32'(hlvl_o[0][1]), 32'd0);
        for (int j = 0; j < 20 * TICK_DIV; j++) step();
        for (int k = 0; k < N_DUT; k++) g_press[k] = 2'b00;
        apply_inputs();
        for (int j = 0; j < 50; j++) step();
        check("sticky.hold_level_kept", 32'(hlvl_o[0][0]), 32'd1);
        check("nonsticky.hold_level_cleared", 32'(hlvl_o[1][0]), 32'd0);
        clr[0] = 2'b01;
        step();
        clr[0] = 2'b00;
        check("sticky.cleared_by_clear", 32'(hlvl_o[0][0]), 32'd0);

        // Randomized segments: long presses, short bounces, occasional clear and reset
        for (int k = 0; k < N_DUT; k++)
            for (int c = 0; c < N_CH; c++) begin dur[k][c] = 0; clr_n[k][c] = 0; end
        for (int cyc = 0; cyc < 8000; cyc++) begin
            for (int k = 0; k < N_DUT; k++) begin
                for (int c = 0; c < N_CH; c++) begin
                    if (dur[k][c] == 0) begin
                        g_press[k][c] = ~g_press[k][c];
                        dur[k][c] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 25))
                                                               : int'($urandom_range(25, 140));
                    end
                    dur[k][c]--;
                    if (clr_n[k][c] > 0) begin
                        clr[k][c] = 1'b1;
                        clr_n[k][c]--;
                    end else begin
                        clr[k][c] = 1'b0;
                        if ($urandom_range(0, 399) == 0) clr_n[k][c] = int'($urandom_range(1, 4));
                    end
                end
            end
            apply_inputs();
            if (cyc % 2500 == 1700) begin
                async_reset_now();
                step();
                rst_n = 1'b1;
            end else begin
                step();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multi_channel_press_detector.md
# multi_channel_press_detector

Parametrised N-channel button conditioner: the successor to the single-channel power-on debouncer. Each channel synchronises a raw button, debounces it on a shared slow tick, and reports the debounced level plus one-cycle press, long-press and release events. An optional sticky hold latch reproduces the "hold power-on for 1 s" behaviour. A per-channel clear reproduces the forced-off behaviour. Sits between the board pins and the GTR mode/power logic, and replaces the per-button debouncer and clock-divider pair.

## Interface
- N_CH, 4, number of independent channels
- TICK_DIV, 100000, sys_clk cycles per debounce tick (≥2)
- DB_TICKS, 20, consecutive agreeing ticks needed to accept a press or a release (≥1)
- HOLD_TICKS, 1000, ticks spent in PRESSED before a long-press event (≥1)
- ACTIVE_LOW, 0, 1 = btn_in is inverted before synchronisation
- STICKY_HOLD, 1, 1 = hold_level stays set after release until clear; 0 = hold_level clears on confirmed release

Ports:
- sys_clk  in  1  single clock; all flops on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- btn_in  in  N_CH  raw button inputs, asynchronous to sys_clk
- clear  in  N_CH  synchronous per-channel force-off, level-sensitive
- btn_level  out  N_CH  debounced pressed level
- press_pulse  out  N_CH  one sys_clk pulse on confirmed press
- hold_pulse  out  N_CH  one sys_clk pulse when HOLD_TICKS is reached
- release_pulse  out  N_CH  one sys_clk pulse on confirmed release
- hold_level  out  N_CH  long-press latch (power-on equivalent)
- tick  out  1  shared debounce tick, one cycle wide

## Operation
- Normalisation and sync: p = btn_in ^ {N_CH{ACTIVE_LOW}}. p passes through a 2-flop synchroniser per channel; the output is s. Synchroniser flops reset to 0.
- Tick: a shared counter counts 0..TICK_DIV-1 and wraps. tick = 1 in the cycle where the count equals TICK_DIV-1. Counter width is $clog2(TICK_DIV).
- Per-channel states: IDLE, PRESS_DB, PRESSED, HELD, RELEASE_DB, LOCKOUT. Each channel has one counter cnt, width $clog2(max(DB_TICKS,HOLD_TICKS)+1), and a return flag ret_held.
- Transitions are evaluated only on tick, except clear.
  - IDLE: if s, go to PRESS_DB with cnt=1. If DB_TICKS==1, go directly to PRESSED and fire press.
  - PRESS_DB: if s, increment cnt; when cnt+1==DB_TICKS, go to PRESSED, cnt=0, fire press_pulse. If !s, go to IDLE, cnt=0.
  - PRESSED: if s, increment cnt; when cnt+1==HOLD_TICKS, go to HELD, fire hold_pulse, set hold_level. If !s, go to RELEASE_DB with ret_held=0. In that case cnt is saved in a hold-count shadow and the release count restarts at 1.
  - HELD: if !s, go to RELEASE_DB with ret_held=1 and release count 1. cnt saturates; there is no wrap.
  - RELEASE_DB: if !s, increment the release count; at DB_TICKS, go to IDLE, fire release_pulse, and clear hold_level if STICKY_HOLD==0. If s (bounce), return to PRESSED (ret_held=0, saved hold count restored, so the hold timing is frozen rather than reset) or to HELD (ret_held=1). No pulses fire on a bounce.
  - LOCKOUT: entered only via clear. Waits for !s on DB_TICKS consecutive ticks, then goes to IDLE with no pulses. If s appears mid-count, the count restarts.
- clear[i] high, in any cycle, has highest priority:
  - Channel i goes to LOCKOUT if s, otherwise to IDLE.
  - All counters for channel i are zeroed and hold_level[i]=0.
  - All pulses for channel i are suppressed that cycle.
  - While clear stays high, the channel is held in this condition.
- btn_level = 1 in PRESSED, HELD and RELEASE_DB; 0 in IDLE, PRESS_DB and LOCKOUT.
- Channels are fully independent; only tick is shared.

## Timing
- Reset (rst_n low): all outputs 0, every channel in IDLE, tick counter 0, all cnt 0. Reset asserted mid-operation aborts immediately, with no pulses.
- Outputs are registered. A pulse asserts in the cycle after the tick edge that caused it and lasts exactly 1 cycle.
- Press latency after a clean input edge: 2 sync cycles, plus the wait to the next tick, plus DB_TICKS-1 further ticks, plus 1 cycle.
- Hold_pulse fires exactly HOLD_TICKS ticks after press_pulse (counted from the press tick), provided there is no bounce.
- press_pulse and hold_pulse never coincide on one channel. release_pulse never coincides with either.

## Test plan
Common bench setup: TICK_DIV=10, DB_TICKS=3, HOLD_TICKS=5, N_CH=2.

- Clean press on ch0, held 100 cycles: tick every 10 cycles. press_pulse[0] fires after the 3rd tick with s=1. hold_pulse[0] and hold_level[0]=1 fire 5 ticks later. btn_level[0]=1 throughout.
- Bounce: press ch0 for 2 ticks, release, press again: no press_pulse until 3 consecutive pressed ticks. During release, a 1-tick bounce returns the channel to PRESSED/HELD with no release_pulse.
- Release with STICKY_HOLD=1: after hold, release for 3 ticks. release_pulse[0]=1 and btn_level[0]=0, but hold_level[0] stays 1. Pulse clear[0] → hold_level[0]=0. Repeat with STICKY_HOLD=0: hold_level clears together with release_pulse.
- Clear while pressed: assert clear[1] in HELD while the button is still down. All ch1 outputs go to 0 the next cycle, with no pulses. The button stays down for 20 ticks with no events. After release plus 3 ticks, the channel is in IDLE; a new press produces press_pulse normally.
- Simultaneous channels plus ACTIVE_LOW=1: drive btn_in=2'b00 (both pressed). Both press_pulses fire in the same cycle. Assert rst_n low mid-hold: all outputs go to 0 asynchronously, and after release of reset a full debounce is needed again.
